d_mem_ctrl: RTL and testbench

// Data-memory controller: the responder end of the LSQ memory-request interface.

---
 rtl/d_mem_ctrl_pkg.sv | 20 ++
 rtl/d_mem_sram.sv | 41 ++++
 rtl/d_mem_ctrl.sv | 165 ++++++++++++++++
 tb/tb_d_mem_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/d_mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// d_mem_ctrl_pkg
// Purpose : types and widths shared between the load/store queue and the
//           data-memory controller.
// Contents: D_MEMORY_ADDR_WIDTH - byte address width of a memory request
//           REG_VAL_WIDTH       - data word width
//           memory_op_t         - operation carried by an LSQ memory request
// ---------------------------------------------------------------------------
package d_mem_ctrl_pkg;

  localparam int D_MEMORY_ADDR_WIDTH = 32;
  localparam int REG_VAL_WIDTH       = 32;

  typedef enum logic [1:0] {
    no_mem_op = 2'd0,
    mem_read  = 2'd1,
    mem_write = 2'd2
  } memory_op_t;

endpackage

// File: rtl/d_mem_sram.sv
// ---------------------------------------------------------------------------
// d_mem_sram
// Purpose : behavioural single-port synchronous data SRAM,
//           2**DEPTH_LOG2 words of DATA_W bits, one-cycle read latency.
//           Contents are not reset.
// Ports   : clk      in   clock
//           i_ce     in   chip enable
//           i_we     in   write enable (qualified by i_ce)
//           i_addr   in   word address
//           i_wdata  in   write data
//           o_rdata  out  read data, valid the cycle after a ce & !we access
// ---------------------------------------------------------------------------
module d_mem_sram #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  i_ce,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     o_rdata
);

  logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];
  logic [DATA_W-1:0] r_rdata;

  // Read data only changes on a read access, so it holds between reads.
  always_ff @(posedge clk) begin
    if (i_ce) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/d_mem_ctrl.sv
// ---------------------------------------------------------------------------
// d_mem_ctrl
// Purpose : data-memory controller, responder end of the LSQ memory-request
//           interface. One load/store in flight; drives a single-port
//           synchronous SRAM and adds EXTRA_LATENCY wait cycles before a
//           one-cycle done pulse (with read data for loads).
// Ports   : clk, reset                          clock, async active-high reset
//           lsq_req_valid/op/address/data  in   request from the LSQ
//           mem_ctrl_ready                 out  request can be accepted
//           mem_ctrl_done                  out  one-cycle completion pulse
//           mem_ctrl_data                  out  load data (held until next load)
//           mem_ctrl_err                   out  out-of-range address, with done
//           sram_ce/we/addr/wdata          out  SRAM access
//           sram_rdata                     in   SRAM read data (1-cycle latency)
// ---------------------------------------------------------------------------
module d_mem_ctrl
  import d_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W        = D_MEMORY_ADDR_WIDTH,
  parameter int DATA_W        = REG_VAL_WIDTH,
  parameter int DEPTH_LOG2    = 10,
  parameter int EXTRA_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lsq_req_valid,
  input  memory_op_t            lsq_req_op,
  input  logic [ADDR_W-1:0]     lsq_req_address,
  input  logic [DATA_W-1:0]     lsq_req_data,
  output logic                  mem_ctrl_ready,
  output logic                  mem_ctrl_done,
  output logic [DATA_W-1:0]     mem_ctrl_data,
  output logic                  mem_ctrl_err,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [DEPTH_LOG2-1:0] sram_addr,
  output logic [DATA_W-1:0]     sram_wdata,
  input  logic [DATA_W-1:0]     sram_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } mem_ctrl_state_t;

  // The counter keeps at least one bit so EXTRA_LATENCY=0 still elaborates.
  localparam int CNT_W      = (EXTRA_LATENCY > 0) ? $clog2(EXTRA_LATENCY + 1) : 1;
  localparam int LAT_LAST_I = (EXTRA_LATENCY > 0) ? EXTRA_LATENCY - 1 : 0;

  mem_ctrl_state_t       r_state;
  logic [CNT_W-1:0]      r_lat_cnt;
  memory_op_t            r_op;
  logic                  r_oob;
  logic                  r_rd_slot;
  logic [DATA_W-1:0]     r_rdata_q;
  logic                  r_ready;
  logic                  r_done;
  logic                  r_err;
  logic [DATA_W-1:0]     r_data;
  logic                  r_sram_ce;
  logic                  r_sram_we;
  logic [DEPTH_LOG2-1:0] r_sram_addr;
  logic [DATA_W-1:0]     r_sram_wdata;

  logic                  w_accept;
  logic                  w_req_oob;
  logic [DATA_W-1:0]     w_load_data;
  logic [DATA_W-1:0]     w_resp_data;

  assign w_accept  = lsq_req_valid & r_ready & (lsq_req_op != no_mem_op);

  // Any address bit above the word index makes the access out of range.
  assign w_req_oob = (lsq_req_address >> (DEPTH_LOG2 + 2)) != '0;

  // Out-of-range loads never touched the SRAM and must return zero.
  assign w_load_data = r_oob ? '0 : sram_rdata;

  // With no wait cycles the SRAM data arrives in the RESPOND cycle itself,
  // so it bypasses rdata_q.
  assign w_resp_data = r_rd_slot ? w_load_data : r_rdata_q;

  // Controller FSM with registered outputs. Ready is registered from
  // "IDLE and not accepting", so it drops in the cycle after an accept and
  // rises one cycle after the FSM returns to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_lat_cnt    <= '0;
      r_op         <= no_mem_op;
      r_oob        <= 1'b0;
      r_rd_slot    <= 1'b0;
      r_rdata_q    <= '0;
      r_ready      <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_data       <= '0;
      r_sram_ce    <= 1'b0;
      r_sram_we    <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
    end else begin
      r_ready   <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_sram_ce <= 1'b0;
      r_sram_we <= 1'b0;
      r_rd_slot <= (r_state == ACCESS);

      if (r_rd_slot && (r_op == mem_read)) begin
        r_rdata_q <= w_load_data;
      end

      case (r_state)
        IDLE: begin
          r_ready <= ~w_accept;
          if (w_accept) begin
            r_state      <= ACCESS;
            r_op         <= lsq_req_op;
            r_oob        <= w_req_oob;
            r_sram_ce    <= ~w_req_oob;
            r_sram_we    <= ~w_req_oob & (lsq_req_op == mem_write);
            r_sram_addr  <= lsq_req_address[DEPTH_LOG2+1:2];
            r_sram_wdata <= lsq_req_data;
          end
        end
        ACCESS: begin
          if (EXTRA_LATENCY > 0) begin
            r_state   <= WAIT;
            r_lat_cnt <= '0;
          end else begin
            r_state <= RESPOND;
          end
        end
        WAIT: begin
          if (r_lat_cnt == CNT_W'(LAT_LAST_I)) begin
            r_state <= RESPOND;
          end else begin
            r_lat_cnt <= r_lat_cnt + CNT_W'(1);
          end
        end
        RESPOND: begin
          r_state <= IDLE;
          r_done  <= 1'b1;
          r_err   <= r_oob;
          if (r_op == mem_read) begin
            r_data <= w_resp_data;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_ctrl_ready = r_ready;
  assign mem_ctrl_done  = r_done;
  assign mem_ctrl_data  = r_data;
  assign mem_ctrl_err   = r_err;
  assign sram_ce        = r_sram_ce;
  assign sram_we        = r_sram_we;
  assign sram_addr      = r_sram_addr;
  assign sram_wdata     = r_sram_wdata;

endmodule

// File: tb/tb_d_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_d_mem_ctrl
// Purpose : directed bench for d_mem_ctrl. Two controller+SRAM pairs share
//           clock and reset: u_dut2 with EXTRA_LATENCY=2, u_dut0 with
//           EXTRA_LATENCY=0. 'sel' chooses which pair the tasks talk to.
// ---------------------------------------------------------------------------
module tb_d_mem_ctrl;
  import d_mem_ctrl_pkg::*;

  logic       clk;
  logic       reset;
  logic       sel;
  memory_op_t reqOp;
  logic [31:0] reqAddr;
  logic [31:0] reqData;
  logic       reqValid2, reqValid0;

  logic        ready2, done2, err2, ce2, we2;
  logic [31:0] data2, wdata2, rdata2;
  logic [9:0]  addr2;
  logic        ready0, done0, err0, ce0, we0;
  logic [31:0] data0, wdata0, rdata0;
  logic [9:0]  addr0;

  logic        wReady, wDone, wErr, wCe;
  logic [31:0] wData;

  int vectors = 0;
  int miscompares = 0;

  int          obsLat, obsReadyLow, obsPulses, obsCe;
  logic [31:0] obsData;
  logic        obsErr;

  d_mem_ctrl #(.DEPTH_LOG2(10), .EXTRA_LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .lsq_req_valid(reqValid2), .lsq_req_op(reqOp),
    .lsq_req_address(reqAddr), .lsq_req_data(reqData),
    .mem_ctrl_ready(ready2), .mem_ctrl_done(done2),
    .mem_ctrl_data(data2), .mem_ctrl_err(err2),
    .sram_ce(ce2), .sram_we(we2), .sram_addr(addr2),
    .sram_wdata(wdata2), .sram_rdata(rdata2)
  );

  d_mem_sram #(.DATA_W(32), .DEPTH_LOG2(10)) u_sram2 (
    .clk(clk), .i_ce(ce2), .i_we(we2), .i_addr(addr2),
    .i_wdata(wdata2), .o_rdata(rdata2)
  );

  d_mem_ctrl #(.DEPTH_LOG2(10), .EXTRA_LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .lsq_req_valid(reqValid0), .lsq_req_op(reqOp),
    .lsq_req_address(reqAddr), .lsq_req_data(reqData),
    .mem_ctrl_ready(ready0), .mem_ctrl_done(done0),
    .mem_ctrl_data(data0), .mem_ctrl_err(err0),
    .sram_ce(ce0), .sram_we(we0), .sram_addr(addr0),
    .sram_wdata(wdata0), .sram_rdata(rdata0)
  );

  d_mem_sram #(.DATA_W(32), .DEPTH_LOG2(10)) u_sram0 (
    .clk(clk), .i_ce(ce0), .i_we(we0), .i_addr(addr0),
    .i_wdata(wdata0), .o_rdata(rdata0)
  );

  assign wReady = sel ? ready0 : ready2;
  assign wDone  = sel ? done0  : done2;
  assign wErr   = sel ? err0   : err2;
  assign wCe    = sel ? ce0    : ce2;
  assign wData  = sel ? data0  : data2;

  // 100 MHz clock; inputs change after posedge, outputs sampled on negedge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guards against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issues one request to the selected pair as soon as it is ready, then
  // watches until ready returns, recording done latency (in cycles after
  // the accepting edge), ready-low cycles, done pulses, ce cycles and the
  // data/err seen with done. Returns at a negedge with ready high.
  task automatic applyStimulus(input memory_op_t op, input logic [31:0] addr,
                               input logic [31:0] data);
    int   guard = 0;
    logic seenReady = 1'b0;
    while (!wReady && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("ready_before_req", {31'b0, wReady}, 32'd1);
    reqOp   = op;
    reqAddr = addr;
    reqData = data;
    if (sel) reqValid0 = 1'b1; else reqValid2 = 1'b1;
    @(posedge clk);
    #1;
    reqValid0 = 1'b0;
    reqValid2 = 1'b0;
    reqOp     = no_mem_op;
    obsLat = -1; obsReadyLow = 0; obsPulses = 0; obsCe = 0;
    obsData = '0; obsErr = 1'b0;
    for (int n = 0; n < 20 && !seenReady; n++) begin
      @(negedge clk);
      if (wCe) obsCe++;
      if (wDone) begin
        obsPulses++;
        if (obsLat < 0) begin
          obsLat  = n;
          obsData = wData;
          obsErr  = wErr;
        end
      end
      if (wReady) seenReady = 1'b1;
      else obsReadyLow++;
    end
  endtask

  task automatic expectTxn(input string tag, input int lat, input int readyLow,
                           input int ceCycles, input logic [31:0] data,
                           input logic err);
    checkOutput({tag, "_lat"},      32'(obsLat),      32'(lat));
    checkOutput({tag, "_readylow"}, 32'(obsReadyLow), 32'(readyLow));
    checkOutput({tag, "_pulses"},   32'(obsPulses),   32'd1);
    checkOutput({tag, "_ce"},       32'(obsCe),       32'(ceCycles));
    checkOutput({tag, "_data"},     obsData,          data);
    checkOutput({tag, "_err"},      {31'b0, obsErr},  {31'b0, err});
  endtask

  // Directed sequence: reset behaviour, latency-2 pair, then latency-0 pair.
  initial begin
    int doneCount;
    int lowCount;
    int ceCount;

    reset = 1'b1; sel = 1'b0;
    reqValid2 = 1'b0; reqValid0 = 1'b0;
    reqOp = no_mem_op; reqAddr = '0; reqData = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_ready", {31'b0, ready2}, 32'd0);
    checkOutput("rst_done",  {31'b0, done2},  32'd0);
    checkOutput("rst_err",   {31'b0, err2},   32'd0);
    checkOutput("rst_data",  data2,           32'd0);
    checkOutput("rst_ce",    {31'b0, ce2},    32'd0);
    checkOutput("rst_we",    {31'b0, we2},    32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", {31'b0, ready2}, 32'd1);

    // Reset asserted in the middle of ACCESS drops the transaction.
    reqOp = mem_write; reqAddr = 32'h40; reqData = 32'h0000_0077;
    reqValid2 = 1'b1;
    @(posedge clk);
    #1;
    reqValid2 = 1'b0; reqOp = no_mem_op;
    checkOutput("midrst_ce_before", {31'b0, ce2}, 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_ce_async", {31'b0, ce2}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    doneCount = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done2) doneCount++;
    end
    checkOutput("midrst_no_done", 32'(doneCount), 32'd0);
    checkOutput("midrst_ready",   {31'b0, ready2}, 32'd1);
    checkOutput("midrst_ce_idle", {31'b0, ce2},    32'd0);

    // EXTRA_LATENCY=2: done 4 cycles after accept, ready low 5 cycles.
    applyStimulus(mem_write, 32'h40, 32'hDEAD_BEEF);
    expectTxn("l2_wr40", 4, 5, 1, 32'h0, 1'b0);
    applyStimulus(mem_read, 32'h40, 32'h0);
    expectTxn("l2_rd40", 4, 5, 1, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(mem_read, 32'h43, 32'h0);
    expectTxn("l2_rd43", 4, 5, 1, 32'hDEAD_BEEF, 1'b0);

    // A write leaves the load data untouched.
    applyStimulus(mem_write, 32'h0, 32'hA5A5_A5A5);
    expectTxn("l2_wr0", 4, 5, 1, 32'hDEAD_BEEF, 1'b0);

    // Out-of-range: no SRAM access, err with done, read returns zero.
    applyStimulus(mem_write, 32'h1000, 32'h5);
    expectTxn("oob_wr", 4, 5, 0, 32'hDEAD_BEEF, 1'b1);
    applyStimulus(mem_read, 32'h1000, 32'h0);
    expectTxn("oob_rd", 4, 5, 0, 32'h0, 1'b1);
    applyStimulus(mem_read, 32'h0, 32'h0);
    expectTxn("oob_not_written", 4, 5, 1, 32'hA5A5_A5A5, 1'b0);

    applyStimulus(mem_write, 32'hC, 32'h1111_1111);
    expectTxn("l2_wrC", 4, 5, 1, 32'hA5A5_A5A5, 1'b0);

    // Valid with no_mem_op is dropped.
    reqOp = no_mem_op; reqAddr = 32'h8; reqData = 32'h9;
    reqValid2 = 1'b1;
    @(posedge clk);
    #1;
    reqValid2 = 1'b0;
    doneCount = 0; lowCount = 0; ceCount = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done2) doneCount++;
      if (!ready2) lowCount++;
      if (ce2) ceCount++;
    end
    checkOutput("nop_done",  32'(doneCount), 32'd0);
    checkOutput("nop_ready", 32'(lowCount),  32'd0);
    checkOutput("nop_ce",    32'(ceCount),   32'd0);

    // A request arriving while ready=0 is lost.
    reqOp = mem_write; reqAddr = 32'h10; reqData = 32'h3333_3333;
    reqValid2 = 1'b1;
    @(posedge clk);
    #1;
    reqAddr = 32'hC; reqData = 32'h2222_2222;
    @(posedge clk);
    #1;
    reqValid2 = 1'b0; reqOp = no_mem_op;
    doneCount = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (done2) doneCount++;
    end
    checkOutput("lost_done_count", 32'(doneCount), 32'd1);
    applyStimulus(mem_read, 32'hC, 32'h0);
    expectTxn("lost_rdC", 4, 5, 1, 32'h1111_1111, 1'b0);
    applyStimulus(mem_read, 32'h10, 32'h0);
    expectTxn("lost_rd10", 4, 5, 1, 32'h3333_3333, 1'b0);

    // Back-to-back write then read, second issued as soon as ready rises.
    applyStimulus(mem_write, 32'h8, 32'hCAFE_F00D);
    expectTxn("b2b_wr8", 4, 5, 1, 32'h3333_3333, 1'b0);
    applyStimulus(mem_read, 32'h8, 32'h0);
    expectTxn("b2b_rd8", 4, 5, 1, 32'hCAFE_F00D, 1'b0);

    // EXTRA_LATENCY=0: done 2 cycles after accept, ready low 3 cycles.
    sel = 1'b1;
    applyStimulus(mem_write, 32'h0, 32'h0000_1234);
    expectTxn("l0_wr0", 2, 3, 1, 32'h0, 1'b0);
    applyStimulus(mem_read, 32'h0, 32'h0);
    expectTxn("l0_rd0", 2, 3, 1, 32'h0000_1234, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
